// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Brief    : VGA raster timing generator with a half-rate pixel clock, x/y
//            counters, sync/blank decode and a start-of-vertical-blank tick.
// Revision : 1.0
// ============================================================================
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active_pixels,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK,
    output logic       frame_tick
);

    localparam int         c_h_total    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         c_v_total    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] c_x_max      = 10'(c_h_total - 1);
    localparam logic [9:0] c_y_max      = 10'(c_v_total - 1);
    localparam logic [9:0] c_h_active   = 10'(H_ACTIVE);
    localparam logic [9:0] c_v_active   = 10'(V_ACTIVE);
    localparam logic [9:0] c_hs_first   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_hs_last    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_vs_first   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_vs_last    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic       r_phase;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_frame_tick;

    logic       w_step;
    logic       w_x_wrap;
    logic       w_y_wrap;
    logic [9:0] w_x_next;
    logic [9:0] w_y_next;
    logic       w_active;

    // A pixel lasts two clks; the counters advance at the end of phase 1.
    assign w_step   = enable & r_phase;
    assign w_x_wrap = (r_x == c_x_max);
    assign w_y_wrap = (r_y == c_y_max);

    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_step) begin
            if (w_x_wrap) begin
                w_x_next = '0;
                w_y_next = w_y_wrap ? '0 : r_y + 10'd1;
            end else begin
                w_x_next = r_x + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase      <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            if (enable) begin
                r_phase <= ~r_phase;
            end
            r_x          <= w_x_next;
            r_y          <= w_y_next;
            // High in the clk right after the step that lands on (0, V_ACTIVE).
            r_frame_tick <= w_step & w_x_wrap & (w_y_next == c_v_active);
        end
    end

    assign w_active      = (r_x < c_h_active) && (r_y < c_v_active);

    assign x             = r_x;
    assign y             = r_y;
    assign active_pixels = w_active;
    assign VGA_BLANK_N   = w_active;
    assign VGA_HS        = ~((r_x >= c_hs_first) && (r_x <= c_hs_last));
    assign VGA_VS        = ~((r_y >= c_vs_first) && (r_y <= c_vs_last));
    assign VGA_SYNC_N    = 1'b0;
    assign VGA_CLK       = r_phase;
    assign frame_tick    = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vga_timing
// Brief    : Directed self-checking bench for vga_timing (full-width lines,
//            shortened frame: 8 active lines, sync on lines 10..11, 15 total).
// Revision : 1.0
// ============================================================================
module tb_vga_timing;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [9:0] x;
    logic [9:0] y;
    logic       active_pixels;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic       VGA_CLK;
    logic       frame_tick;

    vga_timing #(
        .H_ACTIVE (640),
        .H_FP     (16),
        .H_SYNC   (96),
        .H_BP     (48),
        .V_ACTIVE (8),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .x             (x),
        .y             (y),
        .active_pixels (active_pixels),
        .VGA_HS        (VGA_HS),
        .VGA_VS        (VGA_VS),
        .VGA_BLANK_N   (VGA_BLANK_N),
        .VGA_SYNC_N    (VGA_SYNC_N),
        .VGA_CLK       (VGA_CLK),
        .frame_tick    (frame_tick)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Per-clk observer: sampled on the falling edge, away from the active edge.
    logic mon_en = 1'b0;
    int   cyc, hs_low, vs_low, act_cnt, tick_cnt, first_tick, last_tick;
    int   hs_err, vs_err, act_err, blank_err, sync_err, range_err, tick_pos_err;
    int   first_hs_x, max_x;
    logic exp_act;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            exp_act = (x < 10'd640) && (y < 10'd8);
            if (!VGA_HS) hs_low++;
            if (!VGA_VS) vs_low++;
            if (!VGA_HS && first_hs_x < 0) first_hs_x = int'(x);
            if (int'(x) > max_x) max_x = int'(x);
            if (VGA_HS !== !((x >= 10'd656) && (x <= 10'd751))) hs_err++;
            if (VGA_VS !== !((y >= 10'd10) && (y <= 10'd11))) vs_err++;
            if (active_pixels !== exp_act) act_err++;
            if (VGA_BLANK_N !== exp_act) blank_err++;
            if (VGA_SYNC_N !== 1'b0) sync_err++;
            if (x > 10'd799 || y > 10'd14) range_err++;
            if (VGA_CLK && active_pixels) act_cnt++;
            if (frame_tick) begin
                tick_cnt++;
                if (first_tick < 0) first_tick = cyc;
                last_tick = cyc;
                if (!(x == 10'd0 && y == 10'd8 && VGA_CLK == 1'b0)) tick_pos_err++;
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int frz_err;
    int tick_before;

    initial begin
        cyc = 0; hs_low = 0; vs_low = 0; act_cnt = 0; tick_cnt = 0;
        first_tick = -1; last_tick = -1; first_hs_x = -1; max_x = 0;
        hs_err = 0; vs_err = 0; act_err = 0; blank_err = 0; sync_err = 0;
        range_err = 0; tick_pos_err = 0; frz_err = 0;
        enable = 1'b0;
        rst    = 1'b0;

        // Asynchronous reset, observed before any clock edge arrives.
        #3 rst = 1'b1;
        #2;
        check_val("rst_x", 32'(x), 32'd0);
        check_val("rst_y", 32'(y), 32'd0);
        check_val("rst_vga_clk", 32'(VGA_CLK), 32'd0);
        check_val("rst_active", 32'(active_pixels), 32'd1);
        check_val("rst_blank_n", 32'(VGA_BLANK_N), 32'd1);
        check_val("rst_hs", 32'(VGA_HS), 32'd1);
        check_val("rst_vs", 32'(VGA_VS), 32'd1);
        check_val("rst_sync_n", 32'(VGA_SYNC_N), 32'd0);
        check_val("rst_tick", 32'(frame_tick), 32'd0);

        repeat (3) @(negedge clk);
        #1;
        rst    = 1'b0;
        enable = 1'b1;
        mon_en = 1'b1;

        // First pixel step lands on the second edge after reset release.
        wait_cyc(1);
        check_val("edge1_x", 32'(x), 32'd0);
        check_val("edge1_vga_clk", 32'(VGA_CLK), 32'd1);
        wait_cyc(2);
        check_val("edge2_x", 32'(x), 32'd1);
        check_val("edge2_vga_clk", 32'(VGA_CLK), 32'd0);

        // One full line: 1600 clks.
        wait_cyc(1600);
        check_val("line_x", 32'(x), 32'd0);
        check_val("line_y", 32'(y), 32'd1);
        check_val("line_max_x", 32'(max_x), 32'd799);
        check_val("line_hs_low", 32'(hs_low), 32'd192);
        check_val("line_hs_first_x", 32'(first_hs_x), 32'd656);
        check_val("line_active_steps", 32'(act_cnt), 32'd640);

        // One full frame: 15 lines * 800 px * 2 clks = 24000 clks.
        wait_cyc(24000);
        check_val("frame_x", 32'(x), 32'd0);
        check_val("frame_y", 32'(y), 32'd0);
        check_val("frame_active_steps", 32'(act_cnt), 32'd5120);
        check_val("frame_vs_low", 32'(vs_low), 32'd3200);
        check_val("frame_tick_cnt", 32'(tick_cnt), 32'd1);
        check_val("frame_tick_first", 32'(first_tick), 32'd12800);

        wait_cyc(36802);
        check_val("tick2_cnt", 32'(tick_cnt), 32'd2);
        check_val("tick_period", 32'(last_tick - first_tick), 32'd24000);

        // Freeze at (300,5) of the third frame for 100 clks.
        wait_cyc(56600);
        check_val("pre_freeze_x", 32'(x), 32'd300);
        check_val("pre_freeze_y", 32'(y), 32'd5);
        tick_before = tick_cnt;
        enable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (x != 10'd300 || y != 10'd5 || VGA_CLK !== 1'b0 || frame_tick !== 1'b0)
                frz_err++;
        end
        check_val("freeze_hold", 32'(frz_err), 32'd0);
        check_val("freeze_no_tick", 32'(tick_cnt - tick_before), 32'd0);
        enable = 1'b1;
        wait_cyc(56701);
        check_val("resume1_x", 32'(x), 32'd300);
        check_val("resume1_vga_clk", 32'(VGA_CLK), 32'd1);
        wait_cyc(56702);
        check_val("resume2_x", 32'(x), 32'd301);

        // Run to (700,11): inside both sync pulses, then reset mid-line.
        wait_cyc(67100);
        check_val("pre_rst_x", 32'(x), 32'd700);
        check_val("pre_rst_y", 32'(y), 32'd11);
        check_val("pre_rst_hs", 32'(VGA_HS), 32'd0);
        check_val("pre_rst_vs", 32'(VGA_VS), 32'd0);

        check_val("run_hs_decode_err", 32'(hs_err), 32'd0);
        check_val("run_vs_decode_err", 32'(vs_err), 32'd0);
        check_val("run_active_err", 32'(act_err), 32'd0);
        check_val("run_blank_err", 32'(blank_err), 32'd0);
        check_val("run_sync_n_err", 32'(sync_err), 32'd0);
        check_val("run_range_err", 32'(range_err), 32'd0);
        check_val("run_tick_pos_err", 32'(tick_pos_err), 32'd0);
        check_val("run_tick_cnt", 32'(tick_cnt), 32'd3);

        mon_en = 1'b0;
        #3 rst = 1'b1;
        #1;
        check_val("arst_x", 32'(x), 32'd0);
        check_val("arst_y", 32'(y), 32'd0);
        check_val("arst_hs", 32'(VGA_HS), 32'd1);
        check_val("arst_vs", 32'(VGA_VS), 32'd1);
        check_val("arst_tick", 32'(frame_tick), 32'd0);
        check_val("arst_vga_clk", 32'(VGA_CLK), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("arst_hold_x", 32'(x), 32'd0);
        check_val("arst_hold_vga_clk", 32'(VGA_CLK), 32'd0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
